rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters, range 2..4.
REQ-002 SHALL have parameter ADDR_W, default 12: ROM address width (4096 entries).
REQ-003 SHALL have parameter DATA_W, default 8: ROM data width.
REQ-004 SHALL have parameter BURST_MAX, default 8: maximum consecutive locked grants while another requester waits.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester read request.
REQ-008 SHALL have port lock  input  NUM_REQ  requester asks to keep the grant next cycle.
REQ-009 SHALL have port addr  input  NUM_REQ*ADDR_W  per-requester address; slice i belongs to requester i.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot or zero; the request is accepted this cycle.
REQ-011 SHALL have port rvalid  output  NUM_REQ  one-hot or zero; rdata belongs to requester i.
REQ-012 SHALL have port rdata  output  DATA_W  shared read data, equal to rom_dout.
REQ-013 SHALL have port rom_addr  output  ADDR_W  address to the synchronous ROM.
REQ-014 SHALL have port rom_dout  input  DATA_W  ROM data, valid one cycle after its address.

Function
REQ-015 SHALL be combinational from req, lock and state to gnt and rom_addr; at most one gnt bit high per cycle.
REQ-016 SHALL drive rom_addr = addr slice of the granted requester; 0 when no grant.
REQ-017 SHALL register owner/valid for the grant; rvalid[i] high exactly in the cycle after gnt[i]; latency 1, throughput 1 read/cycle; back-to-back grants to different requesters allowed.
REQ-018 SHALL give the lock path precedence: if last-cycle owner j had gnt with lock[j]=1, req[j]=1 this cycle, and (burst_cnt < BURST_MAX-1 or no other req) -> grant j.
REQ-019 SHALL count in burst_cnt the consecutive locked grants to the same owner; reset to 0 on owner change, idle cycle or lock release; saturate at BURST_MAX-1.
REQ-020 SHALL force release when burst_cnt = BURST_MAX-1 and another request is pending: grant goes to the arbitration winner excluding j.
REQ-021 SHALL grant nothing when req = 0; a request withdrawn before grant has no effect.
REQ-022 SHALL ignore lock on a cycle with no grant to that requester.
REQ-023 SHALL keep rdata = rom_dout unregistered; it is undefined when rvalid = 0.

Reset
REQ-024 SHALL, while rst_n=0, force gnt=0, rvalid=0, rom_addr=0, burst_cnt=0, rr pointer=0, owner invalid.
REQ-025 SHALL drop any in-flight response on reset; no rvalid for it after reset release.
REQ-026 SHALL allow a grant in the first clock after rst_n rises.

Configuration
REQ-027 SHALL select round-robin arbitration when ROM_ARB_RR_EN is defined: winner = first requesting index at or after rr pointer; pointer <= winner+1 mod NUM_REQ on every non-locked grant.
REQ-028 SHALL, without ROM_ARB_RR_EN, use fixed priority (lowest index wins); forced release picks the lowest requesting index other than j; no rr pointer exists.

Structure
REQ-029 SHALL place the default widths (ADDR_W=12, DATA_W=8) and the burst-counter width function in shared package rom_arb_pkg.
REQ-030 SHALL implement winner selection in sub-module arb_pick (req vector, start index, exclude mask -> one-hot winner).

Verification
REQ-031 SHALL cover: single req[0], addr=0x000, ROM mem[0]=0xC8 -> gnt[0] cycle N, rvalid[0] cycle N+1, rdata=0xC8.
REQ-032 SHALL cover: req=2'b11 continuous, no lock, RR build -> grants alternate 0,1,0,1; fixed build -> gnt[0] every cycle.
REQ-033 SHALL cover: req[0] with lock=1 plus req[1], BURST_MAX=8 -> 8 consecutive gnt[0], then gnt[1] in cycle 9.
REQ-034 SHALL cover: lock[0]=1 and only req[0] for 20 cycles -> gnt[0] all 20 cycles, no forced release.
REQ-035 SHALL cover: rst_n low in the cycle after gnt[1] -> rvalid=0, rr pointer=0; first grant after release follows reset priority.
REQ-036 SHALL cover: addr0=0x7FF, addr1=0x040 back-to-back -> rdata 0x8C to requester 0, then 0x80 to requester 1.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared widths and sizing helpers for the ROM arbiter.
// Used by rom_arbiter and arb_pick.
package rom_arb_pkg;

   localparam int ROM_ADDR_W = 12;
   localparam int ROM_DATA_W = 8;

   // The burst counter saturates at burst_max-1, so clog2(burst_max) bits suffice.
   function automatic int burst_cnt_width(input int burst_max);
      return (burst_max < 2) ? 1 : $clog2(burst_max);
   endfunction

   function automatic int idx_width(input int num_req);
      return (num_req < 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Picks the first eligible requester at or after a start index, wrapping around.
// The requesters in excl are never picked; the output is one-hot or zero.
module arb_pick
   import rom_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 1
)(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   input  logic [N-1:0]     excl,
   output logic [N-1:0]     win
);

   logic [N-1:0]     elig;
   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic             found;
   logic [IDX_W-1:0] off;
   logic [IDX_W:0]   sum;

   always_comb begin
      elig  = req & ~excl;
      // Rotate so that bit 0 of rot is the requester at the start index.
      dbl   = {elig, elig} >> start;
      rot   = dbl[N-1:0];
      found = 1'b0;
      off   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = IDX_W'(k);
         end
      end
      sum = {1'b0, start} + {1'b0, off};
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      win = '0;
      for (int i = 0; i < N; i++) begin
         if (found && (sum == (IDX_W+1)'(i))) win[i] = 1'b1;
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM among NUM_REQ requesters with lockable, length-limited bursts.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_W    = ROM_ADDR_W,
   parameter int DATA_W    = ROM_DATA_W,
   parameter int BURST_MAX = 8
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        lock,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_dout
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = burst_cnt_width(BURST_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX - 1);

   logic [IDX_W-1:0]   owner_q;
   logic               hold_q;
   logic [CNT_W-1:0]   burst_cnt_q;
   logic [NUM_REQ-1:0] rvalid_q;
   logic [IDX_W-1:0]   start_idx;
   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] excl_mask;
   logic [NUM_REQ-1:0] pick_win;
   logic [NUM_REQ-1:0] gnt_c;
   logic [IDX_W-1:0]   gnt_idx;
   logic               others_req;
   logic               lock_cand;
   logic               take_lock;
   logic               force_rel;

`ifdef ROM_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr_q;
   assign start_idx = rr_ptr_q;
`else
   assign start_idx = '0;
`endif

   always_comb begin
      owner_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) owner_mask[i] = (owner_q == IDX_W'(i));
   end

   // hold_q means the previous owner was granted with lock asserted.
   assign others_req = |(req & ~owner_mask);
   assign lock_cand  = hold_q & (|(req & owner_mask));
   assign take_lock  = lock_cand & ((burst_cnt_q != CNT_MAX) | ~others_req);
   assign force_rel  = lock_cand & ~take_lock;
   assign excl_mask  = force_rel ? owner_mask : '0;

   arb_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .start (start_idx),
      .excl  (excl_mask),
      .win   (pick_win)
   );

   assign gnt_c = take_lock ? owner_mask : pick_win;
   assign gnt   = rst_n ? gnt_c : '0;

   always_comb begin
      gnt_idx  = '0;
      rom_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx  = IDX_W'(i);
            rom_addr = addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= '0;
         hold_q      <= 1'b0;
         burst_cnt_q <= '0;
         rvalid_q    <= '0;
      end else begin
         rvalid_q <= gnt;
         hold_q   <= |(gnt & lock);
         if (|gnt) owner_q <= gnt_idx;
         if (take_lock) begin
            if (burst_cnt_q != CNT_MAX) burst_cnt_q <= burst_cnt_q + 1'b1;
         end else begin
            burst_cnt_q <= '0;
         end
      end
   end

`ifdef ROM_ARB_RR_EN
   // Locked grants leave the pointer alone so a burst does not skew fairness.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else if ((|gnt) && !take_lock) begin
         rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end
`endif

   assign rvalid = rvalid_q;
   assign rdata  = rom_dout;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a rule-level model.
module tb_rom_arbiter;

   localparam int N  = 2;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int BM = 8;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req   = '0;
   logic [N-1:0]    lock  = '0;
   logic [AW-1:0]   a0    = '0;
   logic [AW-1:0]   a1    = '0;
   logic [N*AW-1:0] addr;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_dout;
   logic [DW-1:0]   mem [0:4095];

   int n_checks = 0;
   int n_fail   = 0;

   assign addr = {a1, a0};

   rom_arbiter #(
      .NUM_REQ   (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .BURST_MAX (BM)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .lock     (lock),
      .addr     (addr),
      .gnt      (gnt),
      .rvalid   (rvalid),
      .rdata    (rdata),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(posedge clk) rom_dout <= mem[rom_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_owner = 0;
   int            m_cnt   = 0;
   int            m_ptr   = 0;
   int            m_prev  = -1;
   bit            m_hold  = 1'b0;
   logic [AW-1:0] m_prev_addr = '0;

   function automatic int pick(input logic [N-1:0] r, input int excl, input int ptr);
`ifdef ROM_ARB_RR_EN
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (r[i] && i != excl) return i;
      end
`else
      for (int i = 0; i < N; i++) if (r[i] && i != excl && ptr >= 0) return i;
`endif
      return -1;
   endfunction

   always @(negedge clk) begin
      int            win;
      bit            locked;
      logic [N-1:0]  eg;
      logic [N-1:0]  er;
      logic [AW-1:0] ea;
      if (!rst_n) begin
         check("rst_gnt", 32'(gnt), 32'd0);
         check("rst_rvalid", 32'(rvalid), 32'd0);
         check("rst_rom_addr", 32'(rom_addr), 32'd0);
         m_hold = 1'b0; m_cnt = 0; m_ptr = 0; m_prev = -1; m_owner = 0;
      end else begin
         er = (m_prev >= 0) ? N'(1 << m_prev) : '0;
         locked = 1'b0;
         if (m_hold && req[m_owner]) begin
            if (m_cnt < BM - 1 || (32'(req) & ~(32'd1 << m_owner)) == 0) begin
               win = m_owner;
               locked = 1'b1;
            end else begin
               win = pick(req, m_owner, m_ptr);
            end
         end else begin
            win = pick(req, -1, m_ptr);
         end
         eg = (win >= 0) ? N'(1 << win) : '0;
         ea = (win < 0) ? '0 : ((win == 0) ? a0 : a1);
         check("gnt", 32'(gnt), 32'(eg));
         check("rom_addr", 32'(rom_addr), 32'(ea));
         check("rvalid", 32'(rvalid), 32'(er));
         if (er != 0) check("rdata", 32'(rdata), 32'(mem[m_prev_addr]));
         m_cnt  = locked ? ((m_cnt + 1 > BM - 1) ? BM - 1 : m_cnt + 1) : 0;
         m_hold = (win >= 0) && lock[win];
         if (win >= 0) m_owner = win;
         if (win >= 0 && !locked) m_ptr = (win + 1) % N;
         m_prev = win;
         m_prev_addr = ea;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [AW-1:0] x0, input logic [AW-1:0] x1);
      @(posedge clk);
      #1;
      req = r; lock = l; a0 = x0; a1 = x1;
   endtask

   initial begin
      logic [N-1:0] exp_g;
      int mode;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[12'h000] = 8'hC8;
      mem[12'h7FF] = 8'h8C;
      mem[12'h040] = 8'h80;

      // requests held during reset must not be granted
      req = 2'b11; a0 = 12'h005; a1 = 12'h006;
      repeat (3) @(posedge clk);

      // continuous 2'b11 without lock from the reset state
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1; req = 2'b11; lock = 2'b00;
`ifdef ROM_ARB_RR_EN
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b01;
`endif
         @(negedge clk);
         check("both_req_gnt", 32'(gnt), 32'(exp_g));
      end
      drive(2'b00, 2'b00, 12'h000, 12'h000);

      // single read of address 0
      drive(2'b01, 2'b00, 12'h000, 12'h123);
      @(negedge clk);
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_addr", 32'(rom_addr), 32'h000);
      drive(2'b00, 2'b00, 12'h000, 12'h123);
      @(negedge clk);
      check("single_rvalid", 32'(rvalid), 32'h1);
      check("single_rdata", 32'(rdata), 32'hC8);

      // locked burst from requester 0 with requester 1 waiting
      drive(2'b01, 2'b01, 12'h010, 12'h020);
      @(negedge clk);
      check("burst_c1", 32'(gnt), 32'h1);
      for (int c = 2; c <= 9; c++) begin
         drive(2'b11, 2'b01, 12'h010, 12'h020);
         @(negedge clk);
         check("burst_cyc", 32'(gnt), (c <= 8) ? 32'h1 : 32'h2);
      end
      drive(2'b00, 2'b00, 12'h000, 12'h000);

      // lock with no competitor never releases
      for (int c = 0; c < 20; c++) begin
         drive(2'b01, 2'b01, 12'(c), 12'h000);
         @(negedge clk);
         check("solo_lock", 32'(gnt), 32'h1);
      end
      drive(2'b00, 2'b00, 12'h000, 12'h000);

      // back-to-back reads by different requesters
      drive(2'b01, 2'b00, 12'h7FF, 12'h040);
      @(negedge clk);
      check("b2b_addr0", 32'(rom_addr), 32'h7FF);
      drive(2'b10, 2'b00, 12'h7FF, 12'h040);
      @(negedge clk);
      check("b2b_gnt1", 32'(gnt), 32'h2);
      check("b2b_rv0", 32'(rvalid), 32'h1);
      check("b2b_rd0", 32'(rdata), 32'h8C);
      drive(2'b00, 2'b00, 12'h7FF, 12'h040);
      @(negedge clk);
      check("b2b_rv1", 32'(rvalid), 32'h2);
      check("b2b_rd1", 32'(rdata), 32'h80);

      // reset in the cycle after a grant to requester 1
      drive(2'b10, 2'b10, 12'h001, 12'h002);
      @(negedge clk);
      check("pre_rst_gnt", 32'(gnt), 32'h2);
      @(posedge clk);
      #1;
      rst_n = 1'b0; req = 2'b11;
      @(negedge clk);
      check("rst_drop_rv", 32'(rvalid), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_gnt", 32'(gnt), 32'h1);
      check("post_rst_rv", 32'(rvalid), 32'h0);

      // randomized traffic, occasional resets
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 40 == 0) mode = $urandom_range(0, 1);
         @(posedge clk);
         #1;
         rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         if (mode == 0) begin
            req  = N'($urandom_range(0, 3));
            lock = N'($urandom_range(0, 3));
         end else begin
            req  = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 3)) : 2'b11;
            lock = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 3)) : 2'b11;
         end
         a0 = AW'($urandom_range(0, 4095));
         a1 = AW'($urandom_range(0, 4095));
      end
      drive(2'b00, 2'b00, 12'h000, 12'h000);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
